// File: rtl/quad_enc_pkg.sv
// Shared types and the Gray-code direction decode for the quadrature encoder bank.
// Used by quad_enc_channel; no build options live here.
package quad_enc_pkg;

    typedef logic [1:0] qstate_t;  // {A,B}

    localparam qstate_t QSTATE_IDLE = 2'b11;

    typedef enum logic [1:0] {
        QDIR_NONE = 2'd0,
        QDIR_UP   = 2'd1,
        QDIR_DN   = 2'd2,
        QDIR_ERR  = 2'd3
    } qdir_t;

    // Forward order is 00 -> 01 -> 11 -> 10 -> 00; any other single-bit change is reverse.
    function automatic qdir_t qdir(input qstate_t prev, input qstate_t cur);
        qdir_t d;
        d = QDIR_NONE;
        if ((prev ^ cur) == 2'b11) begin
            d = QDIR_ERR;
        end else if (prev != cur) begin
            case ({prev, cur})
                4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: d = QDIR_UP;
                default:                                d = QDIR_DN;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/quad_enc_channel.sv
// One encoder channel: 2-flop synchroniser, optional debounce filter, 1x/4x decoder, bounded counter.
// Define QUAD_ENC_DEBOUNCE_EN to build the per-pin debounce filter; otherwise the filter is a wire.
module quad_enc_channel
    import quad_enc_pkg::*;
#(
    parameter int          WIDTH      = 16,
    parameter int          X4         = 0,
    parameter int unsigned MIN_VAL    = 0,
    parameter int unsigned MAX_VAL    = 2**WIDTH - 1,
    parameter int          WRAP       = 1,
    parameter int          DEB_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a,
    input  logic             b,
    input  logic             clear,
    output logic [WIDTH-1:0] value,
    output logic             step_up,
    output logic             step_dn,
    output logic             err
);

    localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);

    qstate_t sync1, sync2, filt, prev;
    qdir_t   dir;

    // Reset to idle-high so the first post-reset cycle never looks like an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= QSTATE_IDLE;
            sync2 <= QSTATE_IDLE;
        end else begin
            sync1 <= {a, b};
            sync2 <= sync1;
        end
    end

`ifdef QUAD_ENC_DEBOUNCE_EN
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LOAD = DW'(DEB_CYCLES - 1);

    logic [DW-1:0] deb_cnt [2];

    // Down-counter per pin; output flips on the DEB_CYCLES-th consecutive differing cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt <= QSTATE_IDLE;
            for (int i = 0; i < 2; i++) deb_cnt[i] <= DEB_LOAD;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    deb_cnt[i] <= DEB_LOAD;
                end else if (deb_cnt[i] == '0) begin
                    filt[i]    <= sync2[i];
                    deb_cnt[i] <= DEB_LOAD;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] - 1'b1;
                end
            end
        end
    end
`else
    assign filt = sync2;
`endif

    always_comb begin
        dir = QDIR_NONE;
        if (X4 != 0) begin
            dir = qdir(prev, filt);
        end else if (!prev[1] && filt[1]) begin
            dir = filt[0] ? QDIR_UP : QDIR_DN;
        end
    end

    // Clear takes priority over any event in the same cycle and swallows its pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev    <= QSTATE_IDLE;
            value   <= MIN_V;
            step_up <= 1'b0;
            step_dn <= 1'b0;
            err     <= 1'b0;
        end else begin
            prev    <= filt;
            step_up <= 1'b0;
            step_dn <= 1'b0;
            err     <= 1'b0;
            if (clear) begin
                value <= MIN_V;
            end else begin
                case (dir)
                    QDIR_UP: begin
                        step_up <= 1'b1;
                        if (value == MAX_V) value <= (WRAP != 0) ? MIN_V : value;
                        else                value <= value + 1'b1;
                    end
                    QDIR_DN: begin
                        step_dn <= 1'b1;
                        if (value == MIN_V) value <= (WRAP != 0) ? MAX_V : value;
                        else                value <= value - 1'b1;
                    end
                    QDIR_ERR: err <= 1'b1;
                    default:  ;
                endcase
            end
        end
    end

endmodule

// File: rtl/quad_encoder_bank.sv
// N_CH independent quadrature decoders with packed counter output.
// Build option QUAD_ENC_DEBOUNCE_EN enables the per-pin debounce filter in each channel.
module quad_encoder_bank
    import quad_enc_pkg::*;
#(
    parameter int          N_CH       = 2,
    parameter int          WIDTH      = 16,
    parameter int          X4         = 0,
    parameter int unsigned MIN_VAL    = 0,
    parameter int unsigned MAX_VAL    = 2**WIDTH - 1,
    parameter int          WRAP       = 1,
    parameter int          DEB_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_CH-1:0]       a,
    input  logic [N_CH-1:0]       b,
    input  logic [N_CH-1:0]       clear,
    output logic [N_CH*WIDTH-1:0] value,
    output logic [N_CH-1:0]       step_up,
    output logic [N_CH-1:0]       step_dn,
    output logic [N_CH-1:0]       err
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        quad_enc_channel #(
            .WIDTH      (WIDTH),
            .X4         (X4),
            .MIN_VAL    (MIN_VAL),
            .MAX_VAL    (MAX_VAL),
            .WRAP       (WRAP),
            .DEB_CYCLES (DEB_CYCLES)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .a       (a[i]),
            .b       (b[i]),
            .clear   (clear[i]),
            .value   (value[i*WIDTH +: WIDTH]),
            .step_up (step_up[i]),
            .step_dn (step_dn[i]),
            .err     (err[i])
        );
    end

endmodule

// File: tb/tb_quad_encoder_bank.sv
// Directed bench for quad_encoder_bank: 1x wrap, 4x saturate, 4x wrap/err, clear, reset, debounce.
module tb_quad_encoder_bank;

`ifdef QUAD_ENC_DEBOUNCE_EN
    localparam int LAT = 10;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  a_s   [3];
    logic [1:0]  b_s   [3];
    logic [1:0]  clr_s [3];
    logic [31:0] val_s [3];
    logic [1:0]  up_s  [3];
    logic [1:0]  dn_s  [3];
    logic [1:0]  er_s  [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    quad_encoder_bank #(.N_CH(2), .WIDTH(16), .X4(0), .MIN_VAL(0), .MAX_VAL(65535),
                        .WRAP(1), .DEB_CYCLES(8)) u_dut0 (
        .clk(clk), .reset(reset), .a(a_s[0]), .b(b_s[0]), .clear(clr_s[0]),
        .value(val_s[0]), .step_up(up_s[0]), .step_dn(dn_s[0]), .err(er_s[0]));

    quad_encoder_bank #(.N_CH(2), .WIDTH(16), .X4(1), .MIN_VAL(0), .MAX_VAL(5),
                        .WRAP(0), .DEB_CYCLES(8)) u_dut1 (
        .clk(clk), .reset(reset), .a(a_s[1]), .b(b_s[1]), .clear(clr_s[1]),
        .value(val_s[1]), .step_up(up_s[1]), .step_dn(dn_s[1]), .err(er_s[1]));

    quad_encoder_bank #(.N_CH(2), .WIDTH(16), .X4(1), .MIN_VAL(0), .MAX_VAL(65535),
                        .WRAP(1), .DEB_CYCLES(8)) u_dut2 (
        .clk(clk), .reset(reset), .a(a_s[2]), .b(b_s[2]), .clear(clr_s[2]),
        .value(val_s[2]), .step_up(up_s[2]), .step_dn(dn_s[2]), .err(er_s[2]));

    typedef struct {
        logic [1:0]  a;
        logic [1:0]  b;
        logic [15:0] v0;
        logic [15:0] v1;
        logic [1:0]  up;
        logic [1:0]  dn;
        logic [1:0]  er;
    } vec_t;

    vec_t t0 [17];
    vec_t t1 [9];
    vec_t t2 [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive right after a posedge; result is due on the (LAT+1)-th edge afterwards.
    task automatic run_vec(input int d, input vec_t v, input int idx);
        string tag;
        tag = $sformatf("dut%0d_v%0d", d, idx);
        a_s[d] = v.a;
        b_s[d] = v.b;
        repeat (LAT) @(posedge clk);
        #1;
        chk({tag, "_early_pulse"}, {26'd0, up_s[d], dn_s[d], er_s[d]}, 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_v0"}, {16'd0, val_s[d][15:0]}, {16'd0, v.v0});
        chk({tag, "_v1"}, {16'd0, val_s[d][31:16]}, {16'd0, v.v1});
        chk({tag, "_up"}, {30'd0, up_s[d]}, {30'd0, v.up});
        chk({tag, "_dn"}, {30'd0, dn_s[d]}, {30'd0, v.dn});
        chk({tag, "_err"}, {30'd0, er_s[d]}, {30'd0, v.er});
    endtask

    initial begin
        int pulses;

        // 1x, ch0 detents 1,2,3,2 then down through 0 to wrap; ch1 moves once alongside.
        t0[0]  = '{2'b00, 2'b11, 16'd0,     16'd0, 2'b00, 2'b00, 2'b00};
        t0[1]  = '{2'b11, 2'b11, 16'd1,     16'd1, 2'b11, 2'b00, 2'b00};
        t0[2]  = '{2'b10, 2'b11, 16'd1,     16'd1, 2'b00, 2'b00, 2'b00};
        t0[3]  = '{2'b11, 2'b11, 16'd2,     16'd1, 2'b01, 2'b00, 2'b00};
        t0[4]  = '{2'b10, 2'b11, 16'd2,     16'd1, 2'b00, 2'b00, 2'b00};
        t0[5]  = '{2'b11, 2'b11, 16'd3,     16'd1, 2'b01, 2'b00, 2'b00};
        t0[6]  = '{2'b10, 2'b11, 16'd3,     16'd1, 2'b00, 2'b00, 2'b00};
        t0[7]  = '{2'b10, 2'b10, 16'd3,     16'd1, 2'b00, 2'b00, 2'b00};
        t0[8]  = '{2'b11, 2'b10, 16'd2,     16'd1, 2'b00, 2'b01, 2'b00};
        t0[9]  = '{2'b10, 2'b10, 16'd2,     16'd1, 2'b00, 2'b00, 2'b00};
        t0[10] = '{2'b11, 2'b10, 16'd1,     16'd1, 2'b00, 2'b01, 2'b00};
        t0[11] = '{2'b10, 2'b10, 16'd1,     16'd1, 2'b00, 2'b00, 2'b00};
        t0[12] = '{2'b11, 2'b10, 16'd0,     16'd1, 2'b00, 2'b01, 2'b00};
        t0[13] = '{2'b10, 2'b10, 16'd0,     16'd1, 2'b00, 2'b00, 2'b00};
        t0[14] = '{2'b11, 2'b10, 16'd65535, 16'd1, 2'b00, 2'b01, 2'b00};
        t0[15] = '{2'b10, 2'b11, 16'd65535, 16'd1, 2'b00, 2'b00, 2'b00};
        t0[16] = '{2'b11, 2'b11, 16'd0,     16'd1, 2'b01, 2'b00, 2'b00};

        // 4x saturating at 5: eight forward transitions from idle, then one reverse.
        t1[0] = '{2'b11, 2'b10, 16'd1, 16'd0, 2'b01, 2'b00, 2'b00};
        t1[1] = '{2'b10, 2'b10, 16'd2, 16'd0, 2'b01, 2'b00, 2'b00};
        t1[2] = '{2'b10, 2'b11, 16'd3, 16'd0, 2'b01, 2'b00, 2'b00};
        t1[3] = '{2'b11, 2'b11, 16'd4, 16'd0, 2'b01, 2'b00, 2'b00};
        t1[4] = '{2'b11, 2'b10, 16'd5, 16'd0, 2'b01, 2'b00, 2'b00};
        t1[5] = '{2'b10, 2'b10, 16'd5, 16'd0, 2'b01, 2'b00, 2'b00};
        t1[6] = '{2'b10, 2'b11, 16'd5, 16'd0, 2'b01, 2'b00, 2'b00};
        t1[7] = '{2'b11, 2'b11, 16'd5, 16'd0, 2'b01, 2'b00, 2'b00};
        t1[8] = '{2'b10, 2'b11, 16'd4, 16'd0, 2'b00, 2'b01, 2'b00};

        // 4x wrapping: under/overflow at the limits, then double-bit jumps flag err.
        t2[0] = '{2'b10, 2'b11, 16'd65535, 16'd0, 2'b00, 2'b01, 2'b00};
        t2[1] = '{2'b11, 2'b11, 16'd0,     16'd0, 2'b01, 2'b00, 2'b00};
        t2[2] = '{2'b11, 2'b10, 16'd1,     16'd0, 2'b01, 2'b00, 2'b00};
        t2[3] = '{2'b10, 2'b10, 16'd2,     16'd0, 2'b01, 2'b00, 2'b00};
        t2[4] = '{2'b11, 2'b11, 16'd2,     16'd0, 2'b00, 2'b00, 2'b01};
        t2[5] = '{2'b10, 2'b10, 16'd2,     16'd0, 2'b00, 2'b00, 2'b01};
        t2[6] = '{2'b11, 2'b10, 16'd1,     16'd0, 2'b00, 2'b01, 2'b00};
        t2[7] = '{2'b11, 2'b11, 16'd0,     16'd0, 2'b00, 2'b01, 2'b00};

        for (int d = 0; d < 3; d++) begin
            a_s[d] = 2'b11;
            b_s[d] = 2'b11;
            clr_s[d] = 2'b00;
        end

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++)
                if ((up_s[d] | dn_s[d] | er_s[d]) != 2'b00) pulses++;
        end
        chk("idle_pulses", pulses, 0);
        for (int d = 0; d < 3; d++)
            chk($sformatf("reset_value_dut%0d", d), val_s[d], 32'd0);

        for (int i = 0; i < 17; i++) run_vec(0, t0[i], i);
        for (int i = 0; i < 9; i++)  run_vec(1, t1[i], i);
        for (int i = 0; i < 8; i++)  run_vec(2, t2[i], i);

        // Clear on ch1 lands on the same edge as increments on both channels.
        a_s[0] = 2'b00;
        repeat (LAT + 1) @(posedge clk);
        #1;
        a_s[0] = 2'b11;
        repeat (LAT) @(posedge clk);
        #1;
        clr_s[0] = 2'b10;
        @(posedge clk);
        #1;
        clr_s[0] = 2'b00;
        chk("clear_v0", {16'd0, val_s[0][15:0]}, 32'd1);
        chk("clear_v1", {16'd0, val_s[0][31:16]}, 32'd0);
        chk("clear_up", {30'd0, up_s[0]}, 32'd1);
        chk("clear_dn", {30'd0, dn_s[0]}, 32'd0);
        @(posedge clk);
        #1;
        chk("clear_after_up", {30'd0, up_s[0]}, 32'd0);
        chk("clear_after_val", val_s[0], 32'h0000_0001);

`ifdef QUAD_ENC_DEBOUNCE_EN
        // Three-cycle glitch on A must be rejected; a clean edge counts after exactly LAT edges.
        a_s[0] = 2'b10;
        repeat (3) @(posedge clk);
        #1;
        a_s[0] = 2'b11;
        pulses = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk);
            #1;
            if ((up_s[0] | dn_s[0]) != 2'b00) pulses++;
        end
        chk("deb_glitch_pulses", pulses, 0);
        chk("deb_glitch_v0", {16'd0, val_s[0][15:0]}, 32'd1);
        a_s[0] = 2'b10;
        repeat (20) @(posedge clk);
        #1;
        a_s[0] = 2'b11;
        repeat (LAT) @(posedge clk);
        #1;
        chk("deb_edge_early", {30'd0, up_s[0]}, 32'd0);
        @(posedge clk);
        #1;
        chk("deb_edge_up", {30'd0, up_s[0]}, 32'd1);
        chk("deb_edge_v0", {16'd0, val_s[0][15:0]}, 32'd2);
`endif

        // Synchronous reset brings every counter back to MIN_VAL.
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst2_value_dut%0d", d), val_s[d], 32'd0);
            chk($sformatf("rst2_pulse_dut%0d", d), {26'd0, up_s[d], dn_s[d], er_s[d]}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
